result_uart_tx: RTL and testbench
=================================

RESULT_UART_TX -- requirements
Module: result_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning serial bit rate; BAUD_DIV = CLK_FREQ/BAUD (integer, >= 2).
REQ-003 SHALL have port clock  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port valid_in  input  1  one-cycle strobe; x_in/y_in hold a new result.
REQ-006 SHALL have port x_in  input  10  result x coordinate.
REQ-007 SHALL have port y_in  input  9  result y coordinate.
REQ-008 SHALL have port TxD  output  1  UART serial out, idle high.
REQ-009 SHALL have port busy  output  1  high while a packet is in flight.
REQ-010 SHALL have port send_complete  output  1  one-cycle pulse when a packet finishes.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when valid_in is dropped.

Function
REQ-012 SHALL send each accepted result as a 4-byte packet: B0=0xA5, B1=x[7:0], B2={5'b0, y[8], x[9:8]}, B3=y[7:0].
REQ-013 SHALL frame every byte 8N1: start bit 0, data bits LSB first, one stop bit 1.
REQ-014 SHALL hold every bit (start, data, stop) on TxD for exactly BAUD_DIV clock cycles via a baud counter restarted at each bit boundary.
REQ-015 SHALL send bytes back to back: start bit of byte k+1 follows stop bit of byte k with no idle gap; a packet lasts exactly 40*BAUD_DIV cycles.
REQ-016 SHALL use FSM states IDLE, START, DATA, STOP, plus a 2-bit byte index and a 3-bit bit index.
REQ-017 IDLE: TxD=1, busy=0; on valid_in=1, register x_in/y_in, byte index 0 -> START.
REQ-018 START: TxD=0 for BAUD_DIV cycles -> DATA with bit index 0.
REQ-019 DATA: TxD=current byte[bit index]; after BAUD_DIV cycles increment bit index; after bit 7 -> STOP.
REQ-020 STOP: TxD=1 for BAUD_DIV cycles; then if byte index<3, increment it -> START, else -> IDLE.
REQ-021 Latency: valid_in sampled high at edge N SHALL drive TxD=0 and busy=1 from edge N+1 (registered outputs).
REQ-022 On the STOP->IDLE transition edge SHALL register send_complete=1 and busy=0 for exactly one cycle.
REQ-023 valid_in in the cycle send_complete=1 SHALL be accepted (state is IDLE); the next start bit begins the following cycle.
REQ-024 valid_in while busy=1 SHALL be ignored: packet and registered data unchanged; overrun pulses 1 the next cycle.
REQ-025 x_in/y_in changes after acceptance SHALL NOT affect the packet in flight.
REQ-026 TxD SHALL be driven from a register (glitch-free).

Reset
REQ-027 reset=1 at any edge SHALL force IDLE, TxD=1, busy=0, send_complete=0, overrun=0, zero all counters and indexes, clear captured data.
REQ-028 Reset mid-packet SHALL abort it: no send_complete pulse; TxD=1 from the next edge.
REQ-029 valid_in during reset SHALL be ignored.

Verification (CLK_FREQ=4, BAUD=1, so BAUD_DIV=4)
REQ-030 Reset release, no stimulus for 100 cycles -> TxD=1, busy=0, send_complete=0, overrun=0 throughout.
REQ-031 valid_in with x_in=0x2AB, y_in=0x1CD -> decoded bytes 0xA5, 0xAB, 0x06, 0xCD; every bit 4 cycles wide; busy high 160 cycles; one send_complete pulse.
REQ-032 x_in=0x3FF, y_in=0x000 -> bytes 0xA5, 0xFF, 0x03, 0x00.
REQ-033 Second valid_in 20 cycles into a packet -> overrun pulses once; packet bytes unchanged; exactly one send_complete.
REQ-034 valid_in held high in the send_complete cycle -> next start bit on the following edge; two complete packets total, 320+1 cycles from first acceptance to last stop-bit end.
REQ-035 reset pulsed during byte B2 -> TxD=1 next edge, busy=0, no send_complete; a fresh valid_in afterwards yields a correct full packet.

Source files
------------

// File: rtl/result_uart_tx.sv
// Serialises a captured (x, y) result as a 4-byte 8N1 UART packet: 0xA5, x[7:0], {y[8], x[9:8]}, y[7:0].
// All outputs come straight from registers; a new result is accepted only while idle.
module result_uart_tx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       valid_in,
    input  logic [9:0] x_in,
    input  logic [8:0] y_in,
    output logic       TxD,
    output logic       busy,
    output logic       send_complete,
    output logic       overrun
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] baud_reg, baud_next;
    logic [2:0]       bit_reg, bit_next;
    logic [1:0]       byte_reg, byte_next;
    logic [9:0]       x_reg, x_next;
    logic [8:0]       y_reg, y_next;
    logic             txd_reg, txd_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             ovr_reg, ovr_next;

    logic [7:0] pkt_byte [4];
    logic [7:0] cur_byte;
    logic       bit_end;

    assign pkt_byte[0] = 8'hA5;
    assign pkt_byte[1] = x_reg[7:0];
    assign pkt_byte[2] = {5'b00000, y_reg[8], x_reg[9:8]};
    assign pkt_byte[3] = y_reg[7:0];

    assign cur_byte = pkt_byte[byte_reg];
    assign bit_end  = (baud_reg == BAUD_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            byte_reg  <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            txd_reg   <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            byte_reg  <= byte_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            txd_reg   <= txd_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            ovr_reg   <= ovr_next;
        end
    end

    // TxD is computed one cycle ahead so the registered value lines up with the state it belongs to.
    always_comb begin
        state_next = state_reg;
        baud_next  = bit_end ? '0 : baud_reg + CNT_W'(1);
        bit_next   = bit_reg;
        byte_next  = byte_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        txd_next   = txd_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        ovr_next   = valid_in && (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                baud_next = '0;
                txd_next  = 1'b1;
                if (valid_in) begin
                    x_next     = x_in;
                    y_next     = y_in;
                    byte_next  = 2'd0;
                    bit_next   = 3'd0;
                    state_next = START;
                    txd_next   = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    bit_next   = 3'd0;
                    txd_next   = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                        txd_next = cur_byte[bit_reg + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (byte_reg != 2'd3) begin
                        byte_next  = byte_reg + 2'd1;
                        state_next = START;
                        txd_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                        byte_next  = 2'd0;
                        bit_next   = 3'd0;
                        txd_next   = 1'b1;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign TxD           = txd_reg;
    assign busy          = busy_reg;
    assign send_complete = done_reg;
    assign overrun       = ovr_reg;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx with BAUD_DIV = 4: checks every bit cell of each packet,
// busy/send_complete/overrun timing, back-to-back packets and a mid-packet reset.
module tb_result_uart_tx;

    logic       clock;
    logic       reset;
    logic       valid_in;
    logic [9:0] x_in;
    logic [8:0] y_in;
    logic       TxD;
    logic       busy;
    logic       send_complete;
    logic       overrun;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pkt_start;
    int pkt_end;
    int first_start;

    result_uart_tx #(
        .CLK_FREQ(4),
        .BAUD    (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .valid_in     (valid_in),
        .x_in         (x_in),
        .y_in         (y_in),
        .TxD          (TxD),
        .busy         (busy),
        .send_complete(send_complete),
        .overrun      (overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk("idle_txd", {31'd0, TxD}, 32'd1);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_done", {31'd0, send_complete}, 32'd0);
            chk("idle_ovr", {31'd0, overrun}, 32'd0);
        end
    endtask

    // Called at a negedge with the DUT idle; exp holds the four expected bytes {B0,B1,B2,B3}.
    task automatic run_packet(input logic [9:0] x, input logic [8:0] y, input logic [31:0] exp,
                              input int inject_at, input int abort_at);
        logic [7:0] b;
        int         bp;
        int         j;
        logic       ebit;
        valid_in = 1'b1;
        x_in     = x;
        y_in     = y;
        for (int c = 0; c < 160; c++) begin
            @(negedge clock);
            if (c == 0) begin
                valid_in  = 1'b0;
                pkt_start = cyc;
            end
            if (c == 1) begin
                x_in = ~x;
                y_in = ~y;
            end
            if (abort_at >= 0 && c == abort_at + 1) begin
                chk("abort_txd", {31'd0, TxD}, 32'd1);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                chk("abort_done", {31'd0, send_complete}, 32'd0);
                chk("abort_ovr", {31'd0, overrun}, 32'd0);
                reset    = 1'b0;
                valid_in = 1'b0;
                return;
            end
            bp   = c / 4;
            j    = bp % 10;
            b    = exp[31 - 8 * (bp / 10) -: 8];
            ebit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : b[j - 1];
            chk($sformatf("txd_byte%0d_cell%0d", bp / 10, j), {31'd0, TxD}, {31'd0, ebit});
            chk("pkt_busy", {31'd0, busy}, 32'd1);
            chk("pkt_done", {31'd0, send_complete}, 32'd0);
            chk("pkt_ovr", {31'd0, overrun}, {31'd0, (inject_at >= 0 && c == inject_at + 1)});
            if (c == inject_at) begin
                valid_in = 1'b1;
                x_in     = 10'h155;
                y_in     = 9'h0AA;
            end
            if (inject_at >= 0 && c == inject_at + 1) valid_in = 1'b0;
            if (c == abort_at) begin
                reset    = 1'b1;
                valid_in = 1'b1;
            end
        end
        @(negedge clock);
        pkt_end = cyc;
        chk("end_done", {31'd0, send_complete}, 32'd1);
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("end_txd", {31'd0, TxD}, 32'd1);
        chk("end_ovr", {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        valid_in = 1'b1;
        x_in     = 10'h3FF;
        y_in     = 9'h1FF;
        repeat (3) @(negedge clock);
        chk("rst_txd", {31'd0, TxD}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, send_complete}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        reset    = 1'b0;
        valid_in = 1'b0;
        idle(100);

        run_packet(10'h2AB, 9'h1CD, 32'hA5AB06CD, -1, -1);
        idle(5);
        run_packet(10'h3FF, 9'h000, 32'hA5FF0300, -1, -1);
        idle(5);
        run_packet(10'h123, 9'h045, 32'hA5230145, 20, -1);
        idle(5);

        run_packet(10'h0F0, 9'h10F, 32'hA5F0040F, -1, -1);
        first_start = pkt_start;
        run_packet(10'h301, 9'h080, 32'hA5010380, -1, -1);
        chk("chain_span", pkt_end - first_start, 32'd321);
        idle(5);

        run_packet(10'h2AB, 9'h1CD, 32'hA5AB06CD, -1, 90);
        idle(10);
        run_packet(10'h0AA, 9'h155, 32'hA5AA0455, -1, -1);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
